// File: rtl/mul3_res_recon_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mul3_res_recon_pkg
//  Brief   : Shared defaults, state encoding and sizing helpers for the
//            divide-by-constant reconstruction unit.
//  Revision: 1.0  initial release
// ============================================================================
package mul3_res_recon_pkg;

    localparam int c_width_def   = 64;
    localparam int c_chunk_def   = 4;
    localparam int c_divisor_def = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Carry/remainder width: enough bits to hold any legal remainder and the
    // largest carry a digit product can produce.
    function automatic int rw_bits(input int divisor);
        return $clog2(divisor + 1);
    endfunction

    function automatic int ndig_of(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage : mul3_res_recon_pkg
`default_nettype wire

// File: rtl/mul3_res_recon_digit.sv
`default_nettype none
// ============================================================================
//  Module  : mul3_res_recon_digit
//  Brief   : One digit of the multiply-accumulate chain:
//            {carry_out, digit_out} = DIVISOR * digit_in + carry_in.
//  Revision: 1.0  initial release
// ============================================================================
module mul3_res_recon_digit
    import mul3_res_recon_pkg::*;
#(
    parameter int CHUNK   = c_chunk_def,
    parameter int DIVISOR = c_divisor_def,
    localparam int RW     = rw_bits(DIVISOR)
) (
    input  logic [CHUNK-1:0] digit_in,
    input  logic [RW-1:0]    carry_in,
    output logic [CHUNK-1:0] digit_out,
    output logic [RW-1:0]    carry_out
);

    localparam int c_sum_w = CHUNK + RW;

    logic [c_sum_w-1:0] w_sum;

    assign w_sum     = c_sum_w'(DIVISOR) * c_sum_w'(digit_in) + c_sum_w'(carry_in);
    assign digit_out = w_sum[CHUNK-1:0];
    assign carry_out = w_sum[c_sum_w-1:CHUNK];

endmodule : mul3_res_recon_digit
`default_nettype wire

// File: rtl/mul3_res_recon.sv
`default_nettype none
// ============================================================================
//  Module  : mul3_res_recon
//  Brief   : Digit-serial rebuild of dividend = DIVISOR*q + r, LSB digit
//            first, one CHUNK-bit digit per clock, with overflow/error flags.
//  Revision: 1.0  initial release
// ============================================================================
module mul3_res_recon
    import mul3_res_recon_pkg::*;
#(
    parameter int WIDTH   = c_width_def,
    parameter int CHUNK   = c_chunk_def,
    parameter int DIVISOR = c_divisor_def,
    localparam int RW     = rw_bits(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q,
    input  logic [RW-1:0]    r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dividend,
    output logic             ovf,
    output logic             err
);

    localparam int          c_ndig    = ndig_of(WIDTH, CHUNK);
    localparam int          c_cnt_w   = (c_ndig > 1) ? $clog2(c_ndig) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_ndig - 1);
    localparam logic [RW-1:0]      c_div_rw   = RW'(DIVISOR);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_acc;
    logic [RW-1:0]      r_carry;
    logic               r_ovf;
    logic               r_err;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [CHUNK-1:0]   w_digit;
    logic [RW-1:0]      w_carry;

    mul3_res_recon_digit #(
        .CHUNK   (CHUNK),
        .DIVISOR (DIVISOR)
    ) u_digit (
        .digit_in  (r_q[CHUNK-1:0]),
        .carry_in  (r_carry),
        .digit_out (w_digit),
        .carry_out (w_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_q         <= '0;
            r_acc       <= '0;
            r_carry     <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= RUN;
                        r_q        <= q;
                        r_carry    <= r;
                        r_err      <= (r >= c_div_rw);
                        r_ovf      <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    // New digits enter at the top so that after the last
                    // digit the least significant one has reached bit 0.
                    r_acc   <= {w_digit, r_acc[WIDTH-1:CHUNK]};
                    r_q     <= r_q >> CHUNK;
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last_cnt) begin
                        r_state     <= DONE;
                        r_ovf       <= (w_carry != '0);
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dividend  = r_acc;
    assign ovf       = r_ovf;
    assign err       = r_err;

endmodule : mul3_res_recon
`default_nettype wire
